// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 scancode decoder with held-arrow tracking and event FIFO
module ps2_key_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int SKIP_BYTES     = 7
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          key_en,
  input  logic [7:0]                    key_data,
  output logic [7:0]                    keycode,
  output logic                          key_make,
  output logic                          key_ext,
  output logic                          key_strobe,
  output logic [2:0]                    move,
  output logic [9:0]                    ev_data,
  output logic                          ev_valid,
  input  logic                          ev_rd,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SKIP_BYTES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    keycode_q;
  logic          key_make_q, key_ext_q, key_strobe_q;
  logic [3:0]    held_q, held_d;
  logic          overflow_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic ev_push, ev_ext, ev_make;
  logic is_e0, is_f0, is_e1;
  logic pop, full, wr_en, drop;

  assign is_e0 = (key_data == 8'hE0);
  assign is_f0 = (key_data == 8'hF0);
  assign is_e1 = (key_data == 8'hE1);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = '0;
    ev_push = 1'b0;
    ev_ext  = 1'b0;
    ev_make = 1'b0;
    if (key_en) begin
      if (state_q == SKIP) begin
        skip_d = skip_q - SW'(1);
        if (skip_q <= SW'(1)) begin
          state_d = IDLE;
          skip_d  = '0;
        end
      end else if (is_e1) begin
        state_d = SKIP;
        skip_d  = SW'(SKIP_BYTES);
      end else begin
        unique case (state_q)
          IDLE: begin
            if (is_e0)      state_d = EXT;
            else if (is_f0) state_d = BRK;
            else begin
              ev_push = 1'b1;
              ev_make = 1'b1;
            end
          end
          EXT: begin
            if (is_f0)      state_d = EXT_BRK;
            else if (!is_e0) begin
              ev_push = 1'b1;
              ev_ext  = 1'b1;
              ev_make = 1'b1;
              state_d = IDLE;
            end
          end
          BRK: begin
            if (is_e0)      state_d = EXT_BRK;
            else if (!is_f0) begin
              ev_push = 1'b1;
              state_d = IDLE;
            end
          end
          EXT_BRK: begin
            if (!is_e0 && !is_f0) begin
              ev_push = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE) begin
      // A prefix that never gets its final byte is dropped silently.
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        skip_d  = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  always_comb begin
    held_d = held_q;
    if (ev_push && ev_ext) begin
      unique case (key_data)
        8'h75:   held_d[0] = ev_make;
        8'h72:   held_d[1] = ev_make;
        8'h6B:   held_d[2] = ev_make;
        8'h74:   held_d[3] = ev_make;
        default: ;
      endcase
    end
  end

  always_comb begin
    move = 3'd0;
    if (held_q[0])      move = 3'd1;
    else if (held_q[1]) move = 3'd2;
    else if (held_q[2]) move = 3'd3;
    else if (held_q[3]) move = 3'd4;
  end

  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign pop   = ev_rd && (cnt_q != '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_en = ev_push && (!full || pop);
  assign drop  = ev_push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !wr_en) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      skip_q       <= '0;
      tmo_q        <= '0;
      keycode_q    <= '0;
      key_make_q   <= 1'b0;
      key_ext_q    <= 1'b0;
      key_strobe_q <= 1'b0;
      held_q       <= '0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      tmo_q        <= tmo_d;
      held_q       <= held_d;
      key_strobe_q <= ev_push;
      cnt_q        <= cnt_d;
      if (ev_push) begin
        keycode_q  <= key_data;
        key_make_q <= ev_make;
        key_ext_q  <= ev_ext;
      end
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {ev_ext, ev_make, key_data};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign keycode    = keycode_q;
  assign key_make   = key_make_q;
  assign key_ext    = key_ext_q;
  assign key_strobe = key_strobe_q;
  assign ev_data    = mem_q[rd_ptr_q];
  assign ev_valid   = (cnt_q != '0);
  assign ev_count   = cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - table-driven bench for ps2_key_decoder
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_en = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       ev_rd = 1'b0;
  logic [7:0] keycode;
  logic       key_make, key_ext, key_strobe, ev_valid, overflow;
  logic [2:0] move;
  logic [9:0] ev_data;
  logic [2:0] ev_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100), .SKIP_BYTES(7)) dut (
    .clk(clk), .resetn(resetn), .key_en(key_en), .key_data(key_data),
    .keycode(keycode), .key_make(key_make), .key_ext(key_ext),
    .key_strobe(key_strobe), .move(move), .ev_data(ev_data),
    .ev_valid(ev_valid), .ev_rd(ev_rd), .ev_count(ev_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       rd;
    logic       s;
    logic [7:0] c;
    logic       m;
    logic       x;
    logic [2:0] mv;
    logic [2:0] n;
    logic [9:0] h;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic [7:0] d, input logic rd,
                              input logic s, input logic [7:0] c, input logic m,
                              input logic x, input logic [2:0] mv, input logic [2:0] n,
                              input logic [9:0] h);
    vec_t v;
    v.en = en; v.d = d; v.rd = rd; v.s = s; v.c = c;
    v.m = m; v.x = x; v.mv = mv; v.n = n; v.h = h;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, leave them for one rising edge.
  task automatic cycle(input logic en, input logic [7:0] d, input logic rd);
    key_en = en; key_data = d; ev_rd = rd;
    @(posedge clk);
    @(negedge clk);
    key_en = 1'b0; ev_rd = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " keycode"}, 32'(keycode), 0);
    chk({tag, " make"}, 32'(key_make), 0);
    chk({tag, " ext"}, 32'(key_ext), 0);
    chk({tag, " strobe"}, 32'(key_strobe), 0);
    chk({tag, " move"}, 32'(move), 0);
    chk({tag, " ev_data"}, 32'(ev_data), 0);
    chk({tag, " ev_valid"}, 32'(ev_valid), 0);
    chk({tag, " ev_count"}, 32'(ev_count), 0);
    chk({tag, " overflow"}, 32'(overflow), 0);
  endtask

  initial begin
    int strobes;
    logic [7:0] pause_seq [8];

    // Each row: byte/pop applied, then outputs expected one cycle later.
    vecs.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 1, 0, 0, 1, 10'h11C));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h1C, 1, 0, 0, 0, 10'h000));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h1C, 1, 0, 0, 0, 10'h000));
    vecs.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 1, 1, 10'h375));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h75, 1, 1, 1, 1, 10'h375));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 8'h75, 1, 1, 1, 1, 10'h375));
    vecs.push_back(mk(1, 8'h75, 0, 1, 8'h75, 0, 1, 0, 2, 10'h375));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h75, 0, 1, 0, 1, 10'h275));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h75, 0, 1, 0, 0, 10'h000));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h75, 0, 1, 0, 0, 10'h000));
    vecs.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 1, 1, 10'h375));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h75, 1, 1, 1, 1, 10'h375));
    vecs.push_back(mk(1, 8'h6B, 0, 1, 8'h6B, 1, 1, 1, 2, 10'h375));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h6B, 1, 1, 1, 2, 10'h375));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 8'h6B, 1, 1, 1, 2, 10'h375));
    vecs.push_back(mk(1, 8'h75, 0, 1, 8'h75, 0, 1, 3, 3, 10'h375));
    vecs.push_back(mk(1, 8'h74, 0, 1, 8'h74, 1, 0, 3, 4, 10'h375));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h74, 1, 0, 3, 3, 10'h36B));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h74, 1, 0, 3, 2, 10'h275));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h74, 1, 0, 3, 1, 10'h174));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h74, 1, 0, 3, 0, 10'h000));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 8'h74, 1, 0, 3, 0, 10'h000));
    vecs.push_back(mk(1, 8'h6B, 0, 1, 8'h6B, 0, 0, 3, 1, 10'h06B));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 8'h6B, 0, 0, 3, 1, 10'h06B));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h6B, 0, 0, 3, 1, 10'h06B));
    vecs.push_back(mk(1, 8'h6B, 0, 1, 8'h6B, 0, 1, 0, 2, 10'h06B));
    vecs.push_back(mk(1, 8'hE0, 1, 0, 8'h6B, 0, 1, 0, 1, 10'h26B));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h6B, 0, 1, 0, 0, 10'h000));
    vecs.push_back(mk(1, 8'h72, 0, 1, 8'h72, 1, 1, 2, 1, 10'h372));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h72, 1, 1, 2, 1, 10'h372));
    vecs.push_back(mk(1, 8'h72, 0, 1, 8'h72, 1, 1, 2, 2, 10'h372));
    vecs.push_back(mk(1, 8'hE0, 0, 0, 8'h72, 1, 1, 2, 2, 10'h372));
    vecs.push_back(mk(1, 8'hF0, 0, 0, 8'h72, 1, 1, 2, 2, 10'h372));
    vecs.push_back(mk(1, 8'h72, 0, 1, 8'h72, 0, 1, 0, 3, 10'h372));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h72, 0, 1, 0, 2, 10'h372));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h72, 0, 1, 0, 1, 10'h272));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h72, 0, 1, 0, 0, 10'h000));
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, pause_seq[i], 0, 0, 8'h72, 0, 1, 0, 0, 10'h000));
    vecs.push_back(mk(1, 8'h29, 0, 1, 8'h29, 1, 0, 0, 1, 10'h129));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h29, 1, 0, 0, 0, 10'h000));
    vecs.push_back(mk(0, 8'h00, 1, 0, 8'h29, 1, 0, 0, 0, 10'h000));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    resetn = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].en, vecs[i].d, vecs[i].rd);
      chk($sformatf("v%0d strobe", i), 32'(key_strobe), 32'(vecs[i].s));
      chk($sformatf("v%0d keycode", i), 32'(keycode), 32'(vecs[i].c));
      chk($sformatf("v%0d make", i), 32'(key_make), 32'(vecs[i].m));
      chk($sformatf("v%0d ext", i), 32'(key_ext), 32'(vecs[i].x));
      chk($sformatf("v%0d move", i), 32'(move), 32'(vecs[i].mv));
      chk($sformatf("v%0d count", i), 32'(ev_count), 32'(vecs[i].n));
      chk($sformatf("v%0d valid", i), 32'(ev_valid), 32'(vecs[i].n != 0));
      if (vecs[i].n != 0)
        chk($sformatf("v%0d head", i), 32'(ev_data), 32'(vecs[i].h));
    end

    // Stale break prefix expires, so the following byte is a plain make.
    cycle(1, 8'hF0, 0);
    strobes = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_strobe) strobes++;
    end
    chk("timeout no strobe", 32'(strobes), 0);
    cycle(1, 8'h1C, 0);
    chk("timeout strobe", 32'(key_strobe), 1);
    chk("timeout make", 32'(key_make), 1);
    chk("timeout code", 32'(keycode), 32'h1C);
    chk("timeout ext", 32'(key_ext), 0);
    chk("timeout head", 32'(ev_data), 32'h11C);
    cycle(0, 8'h00, 1);
    chk("timeout drained", 32'(ev_count), 0);

    for (int k = 1; k <= 4; k++) cycle(1, 8'(k), 0);
    chk("fill count", 32'(ev_count), 4);
    chk("fill overflow", 32'(overflow), 0);
    cycle(1, 8'h05, 0);
    chk("ovf count", 32'(ev_count), 4);
    chk("ovf flag", 32'(overflow), 1);
    chk("ovf keycode", 32'(keycode), 32'h05);
    chk("ovf strobe", 32'(key_strobe), 1);
    chk("ovf head", 32'(ev_data), 32'h101);
    cycle(1, 8'h06, 1);
    chk("pushpop count", 32'(ev_count), 4);
    chk("pushpop head", 32'(ev_data), 32'h102);
    chk("pushpop keycode", 32'(keycode), 32'h06);
    chk("pushpop overflow", 32'(overflow), 1);

    cycle(1, 8'hE0, 0);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    resetn = 1'b1;
    cycle(1, 8'h1C, 0);
    chk("post reset ext", 32'(key_ext), 0);
    chk("post reset make", 32'(key_make), 1);
    chk("post reset code", 32'(keycode), 32'h1C);
    chk("post reset count", 32'(ev_count), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
